control_unit_fft_iter_pipe: RTL and testbench
=============================================

Name: control_unit_fft_iter_pipe

Overview:
Parametrised successor to the iterative FFT control unit. It sequences LAYERS passes of BUTTERFLYES butterfly operations over the in-place memory and issues one butterfly read per cycle. It generates a write strobe and write indices delayed by the butterfly datapath latency PIPE_LAT, and drains the pipeline at each layer boundary so that reads never overtake pending writes. It adds a START/BUSY/DONE handshake and a global EN stall, and sits between the top-level FFT wrapper and the address generator / butterfly datapath.

Parameters:
LAYERS, 5, number of FFT layers (log2 N); >=1
BUTTERFLYES, 16, butterflies per layer (N/2); >=2
LayWL, 3, layer index width; must satisfy 2^LayWL >= LAYERS
ButtWL, 4, butterfly index width; must satisfy 2^ButtWL >= BUTTERFLYES
PIPE_LAT, 2, cycles from a butterfly's read to its write; >=1

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
EN  in  1  global enable; 0 freezes all state, counters and the delay line
START  in  1  start request; accepted only in IDLE with EN=1
ABORT  in  1  synchronous abort (used only with CU_FFT_ABORT_EN)
RD_EN  out  1  butterfly read strobe
RD_BUTT  out  ButtWL  butterfly index of the current read
RD_LAY  out  LayWL  layer index of the current read
FIRST  out  1  current read belongs to layer 0
LAY_EN  out  1  pulse on the first read of each layer
WR_EN  out  1  butterfly write strobe
WR_BUTT  out  ButtWL  butterfly index of the current write
WR_LAY  out  LayWL  layer index of the current write
BUSY  out  1  high in READ and DRAIN
DONE  out  1  one-cycle pulse after the final write

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; all counters 0; delay line cleared. All outputs are 0.
- States: IDLE, READ, DRAIN, DONE. Every transition and counter update requires EN=1.
- IDLE: START=1 -> READ with butt=0, lay=0. Otherwise stay in IDLE.
- READ: RD_EN=1, RD_BUTT=butt, RD_LAY=lay. FIRST=(lay==0). LAY_EN=(butt==0).
  - butt increments each cycle.
  - At butt==BUTTERFLYES-1: go to DRAIN, load drain counter with PIPE_LAT-1, reset butt to 0.
- DRAIN: RD_EN=0.
  - Drain counter decrements each cycle.
  - At 0: if lay==LAYERS-1 go to DONE; otherwise lay increments and the state returns to READ.
- DONE: DONE=1 for one cycle, then IDLE. START is ignored in DONE.
- Write path: a PIPE_LAT-deep shift register carries {RD_EN, RD_BUTT, RD_LAY}. Its output drives WR_EN, WR_BUTT and WR_LAY. The last write of each layer is therefore in the final DRAIN cycle.
- Timing: per layer BUTTERFLYES+PIPE_LAT cycles. The first read is in the cycle after START is accepted. DONE is high in cycle LAYERS*(BUTTERFLYES+PIPE_LAT)+1, counted from the first READ cycle.
- EN=0: all registers hold, including the delay line. Outputs hold their values, but RD_EN, WR_EN, LAY_EN and DONE are gated to 0 while EN=0.
- START while BUSY or in DONE: ignored, no queuing.
- Reset mid-operation: immediate IDLE. Pending writes are discarded and DONE is not issued.
- Counter widths: wrap never occurs given the parameter constraints. Comparisons are made against parameters zero-extended to the counter widths.

Optional Feature:
CU_FFT_ABORT_EN. When defined, ABORT=1 with EN=1 in any state forces IDLE on the next edge: butt, lay and the drain counter are cleared, the delay line is flushed (WR_EN is 0 from the next cycle), and DONE is not issued. ABORT has priority over START. When not defined, the ABORT port exists but is ignored and the logic is absent.

Decomposition:
- Package fft_iter_pkg: state encoding localparams (IDLE=0, READ=1, DRAIN=2, DONE=3; width 2) and a helper function for the drain-counter width, clog2(PIPE_LAT)+1.
- Sub-module fft_iter_delay_line: a parametrised-width, depth-PIPE_LAT shift register with enable and asynchronous active-low clear. It is instantiated once for the {valid, butt, lay} bundle.

Test Plan:
- Defaults (5/16/2), START pulse: RD_EN has 5 bursts of 16 with 2-cycle gaps; WR_EN trails each burst by 2 cycles; DONE in cycle 91 after the first read; BUSY high for 90 cycles.
- PIPE_LAT=1, LAYERS=1, BUTTERFLYES=2: read butt 0,1; writes 0,1 one cycle later; DONE in cycle 4; FIRST=1 throughout the reads.
- EN low for 3 cycles mid-layer 2 at butt=7: all indices hold and strobes drop. Resumes at butt=7 with no lost or duplicated write; DONE is delayed by exactly 3 cycles.
- START asserted during BUSY and during DONE: no restart. A START in the following IDLE cycle starts a new run with RD_BUTT=0, RD_LAY=0.
- RST low mid-DRAIN of layer 3: all outputs 0 immediately with no further WR_EN; after release the block is in IDLE and a new START gives the full 91-cycle sequence.
- With CU_FFT_ABORT_EN, ABORT at layer 1, butt 5: IDLE next cycle, WR_EN 0 from that cycle, no DONE. Without the macro the same stimulus completes normally.

Source files
------------

// File: rtl/fft_iter_pkg.sv
// Shared definitions for the iterative FFT control unit: state encoding
// and the width helper for the drain counter.
package fft_iter_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_READ  = 2'd1;
  localparam logic [ST_W-1:0] ST_DRAIN = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_READ  = ST_READ,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } state_t;

  // Drain counter must hold PIPE_LAT-1; one spare bit keeps PIPE_LAT=1 legal.
  function automatic int drain_cnt_width(input int pipe_lat);
    return $clog2(pipe_lat) + 1;
  endfunction

endpackage

// File: rtl/fft_iter_delay_line.sv
// Depth-DEPTH shift register that carries the read bundle forward to the
// write side. Holds while en=0; flush clears every stage synchronously.
module fft_iter_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] q_reg;
      logic [WIDTH-1:0] d_next;

      if (gi == 0) begin : g_head
        assign d_next = din;
      end else begin : g_tail
        assign d_next = g_stage[gi-1].q_reg;
      end

      // One pipeline stage: cleared by reset or flush, advances only when enabled.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          q_reg <= '0;
        end else if (flush) begin
          q_reg <= '0;
        end else if (en) begin
          q_reg <= d_next;
        end
      end
    end
  endgenerate

  assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/control_unit_fft_iter_pipe.sv
// Iterative FFT control unit with pipelined write-back.
// Sequences LAYERS passes of BUTTERFLYES reads, drains PIPE_LAT cycles at
// each layer boundary, and replays the read bundle as writes PIPE_LAT later.
// Optional feature macro: CU_FFT_ABORT_EN (enables the synchronous ABORT).
module control_unit_fft_iter_pipe
  import fft_iter_pkg::*;
#(
  parameter int LAYERS      = 5,
  parameter int BUTTERFLYES = 16,
  parameter int LayWL       = 3,
  parameter int ButtWL      = 4,
  parameter int PIPE_LAT    = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              START,
  input  logic              ABORT,
  output logic              RD_EN,
  output logic [ButtWL-1:0] RD_BUTT,
  output logic [LayWL-1:0]  RD_LAY,
  output logic              FIRST,
  output logic              LAY_EN,
  output logic              WR_EN,
  output logic [ButtWL-1:0] WR_BUTT,
  output logic [LayWL-1:0]  WR_LAY,
  output logic              BUSY,
  output logic              DONE
);

  localparam int                DCW       = drain_cnt_width(PIPE_LAT);
  localparam int                DLW       = 1 + ButtWL + LayWL;
  localparam logic [ButtWL-1:0] BUTT_LAST = ButtWL'(BUTTERFLYES - 1);
  localparam logic [LayWL-1:0]  LAY_LAST  = LayWL'(LAYERS - 1);
  localparam logic [DCW-1:0]    DCNT_LOAD = DCW'(PIPE_LAT - 1);

  state_t            state_reg;
  logic [ButtWL-1:0] butt_reg;
  logic [LayWL-1:0]  lay_reg;
  logic [DCW-1:0]    dcnt_reg;
  logic              rd_en_reg;
  logic              first_reg;
  logic              lay_en_reg;
  logic              busy_reg;
  logic              done_reg;

  logic              flush_dl;
  logic [DLW-1:0]    dl_out;

`ifdef CU_FFT_ABORT_EN
  assign flush_dl = ABORT & EN;
`else
  logic abort_unused;
  assign abort_unused = ABORT;
  assign flush_dl     = 1'b0;
`endif

  // Sequencer FSM: counters and registered strobes all advance only with EN.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg  <= S_IDLE;
      butt_reg   <= '0;
      lay_reg    <= '0;
      dcnt_reg   <= '0;
      rd_en_reg  <= 1'b0;
      first_reg  <= 1'b0;
      lay_en_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else if (EN) begin
`ifdef CU_FFT_ABORT_EN
      if (ABORT) begin
        state_reg  <= S_IDLE;
        butt_reg   <= '0;
        lay_reg    <= '0;
        dcnt_reg   <= '0;
        rd_en_reg  <= 1'b0;
        first_reg  <= 1'b0;
        lay_en_reg <= 1'b0;
        busy_reg   <= 1'b0;
        done_reg   <= 1'b0;
      end else
`endif
      begin
        case (state_reg)
          S_IDLE: begin
            if (START) begin
              state_reg  <= S_READ;
              butt_reg   <= '0;
              lay_reg    <= '0;
              rd_en_reg  <= 1'b1;
              first_reg  <= 1'b1;
              lay_en_reg <= 1'b1;
              busy_reg   <= 1'b1;
            end
          end
          S_READ: begin
            lay_en_reg <= 1'b0;
            if (butt_reg == BUTT_LAST) begin
              state_reg <= S_DRAIN;
              butt_reg  <= '0;
              dcnt_reg  <= DCNT_LOAD;
              rd_en_reg <= 1'b0;
              first_reg <= 1'b0;
            end else begin
              butt_reg <= butt_reg + ButtWL'(1);
            end
          end
          S_DRAIN: begin
            if (dcnt_reg == '0) begin
              if (lay_reg == LAY_LAST) begin
                state_reg <= S_DONE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end else begin
                // Next layer index is never 0, so FIRST stays low.
                state_reg  <= S_READ;
                lay_reg    <= lay_reg + LayWL'(1);
                rd_en_reg  <= 1'b1;
                lay_en_reg <= 1'b1;
              end
            end else begin
              dcnt_reg <= dcnt_reg - DCW'(1);
            end
          end
          S_DONE: begin
            state_reg <= S_IDLE;
            done_reg  <= 1'b0;
            lay_reg   <= '0;
          end
          default: begin
            state_reg <= S_IDLE;
          end
        endcase
      end
    end
  end

  fft_iter_delay_line #(
    .WIDTH (DLW),
    .DEPTH (PIPE_LAT)
  ) u_delay (
    .CLK   (CLK),
    .RST   (RST),
    .en    (EN),
    .flush (flush_dl),
    .din   ({rd_en_reg, butt_reg, lay_reg}),
    .dout  (dl_out)
  );

  // Strobes are gated by EN so a stall never repeats a read or write.
  assign RD_EN   = rd_en_reg & EN;
  assign RD_BUTT = butt_reg;
  assign RD_LAY  = lay_reg;
  assign FIRST   = first_reg;
  assign LAY_EN  = lay_en_reg & EN;
  assign BUSY    = busy_reg;
  assign DONE    = done_reg & EN;
  assign WR_EN   = dl_out[DLW-1] & EN;
  assign WR_BUTT = dl_out[DLW-2 -: ButtWL];
  assign WR_LAY  = dl_out[LayWL-1:0];

endmodule

// File: tb/tb_control_unit_fft_iter_pipe.sv
// Scoreboard bench: stimulus pushes expected reads/writes/DONE events with
// their cycle numbers; a negedge monitor pops and compares whenever a DUT
// strobe is seen. Instance 0 uses default parameters, instance 1 is the
// minimal 1-layer / 2-butterfly / PIPE_LAT=1 configuration.
module tb_control_unit_fft_iter_pipe;

  typedef struct {
    int inst;
    int cyc;
    int lay;
    int butt;
    int busy;
  } ev_t;

  localparam int BIG = 1000000;

  logic       CLK;
  logic       RST;
  logic       EN, START, ABORT;
  logic       START_S;
  logic       EN_S, ABORT_S;

  logic       rd_en, first, lay_en, wr_en, busy, done;
  logic [3:0] rd_butt, wr_butt;
  logic [2:0] rd_lay, wr_lay;

  logic       rd_en_s, first_s, lay_en_s, wr_en_s, busy_s, done_s;
  logic [0:0] rd_butt_s, wr_butt_s;
  logic [0:0] rd_lay_s, wr_lay_s;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy_cnt [2];

  ev_t rd_q[$];
  ev_t wr_q[$];
  ev_t dn_q[$];

  control_unit_fft_iter_pipe dut (
    .CLK(CLK), .RST(RST), .EN(EN), .START(START), .ABORT(ABORT),
    .RD_EN(rd_en), .RD_BUTT(rd_butt), .RD_LAY(rd_lay), .FIRST(first),
    .LAY_EN(lay_en), .WR_EN(wr_en), .WR_BUTT(wr_butt), .WR_LAY(wr_lay),
    .BUSY(busy), .DONE(done)
  );

  control_unit_fft_iter_pipe #(
    .LAYERS(1), .BUTTERFLYES(2), .LayWL(1), .ButtWL(1), .PIPE_LAT(1)
  ) dut_s (
    .CLK(CLK), .RST(RST), .EN(EN_S), .START(START_S), .ABORT(ABORT_S),
    .RD_EN(rd_en_s), .RD_BUTT(rd_butt_s), .RD_LAY(rd_lay_s), .FIRST(first_s),
    .LAY_EN(lay_en_s), .WR_EN(wr_en_s), .WR_BUTT(wr_butt_s), .WR_LAY(wr_lay_s),
    .BUSY(busy_s), .DONE(done_s)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic start_run(input int inst, output int s);
    @(posedge CLK);
    #1;
    if (inst == 0) START = 1'b1;
    else START_S = 1'b1;
    @(posedge CLK);
    #1;
    START   = 1'b0;
    START_S = 1'b0;
    s = cyc;
  endtask

  // Expected schedule: read (l,b) at s+l*(B+P)+b, write P later, DONE at
  // s+L*(B+P). Events at or after st_at slip by st_len; events at or after
  // cut are never issued.
  task automatic push_run(input int inst, input int s, input int nl, input int nb,
                          input int pl, input int st_at, input int st_len, input int cut);
    int t;
    for (int l = 0; l < nl; l++) begin
      for (int b = 0; b < nb; b++) begin
        t = s + l * (nb + pl) + b;
        if (t >= st_at) t += st_len;
        if (t < cut) rd_q.push_back('{inst, t, l, b, 0});
        t = s + l * (nb + pl) + b + pl;
        if (t >= st_at) t += st_len;
        if (t < cut) wr_q.push_back('{inst, t, l, b, 0});
      end
    end
    t = s + nl * (nb + pl);
    if (t >= st_at) t += st_len;
    if (t < cut) dn_q.push_back('{inst, t, 0, 0, nl * (nb + pl) + st_len});
  endtask

  // Monitor: one line per observed transaction mismatch.
  initial begin
    ev_t e;
    logic [31:0] v_rde, v_rdb, v_rdl, v_first, v_layen, v_wre, v_wrb, v_wrl, v_busy, v_done;
    busy_cnt[0] = 0;
    busy_cnt[1] = 0;
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        if (i == 0) begin
          v_rde = 32'(rd_en);   v_rdb = 32'(rd_butt); v_rdl = 32'(rd_lay);
          v_first = 32'(first); v_layen = 32'(lay_en);
          v_wre = 32'(wr_en);   v_wrb = 32'(wr_butt); v_wrl = 32'(wr_lay);
          v_busy = 32'(busy);   v_done = 32'(done);
        end else begin
          v_rde = 32'(rd_en_s);   v_rdb = 32'(rd_butt_s); v_rdl = 32'(rd_lay_s);
          v_first = 32'(first_s); v_layen = 32'(lay_en_s);
          v_wre = 32'(wr_en_s);   v_wrb = 32'(wr_butt_s); v_wrl = 32'(wr_lay_s);
          v_busy = 32'(busy_s);   v_done = 32'(done_s);
        end
        if (v_rde != 0) begin
          if (rd_q.size() == 0) check($sformatf("rd_unexpected_i%0d", i), v_rdb, -1);
          else begin
            e = rd_q.pop_front();
            check("rd_inst", 32'(i), e.inst);
            check("rd_cyc", 32'(cyc), e.cyc);
            check("rd_lay", v_rdl, e.lay);
            check("rd_butt", v_rdb, e.butt);
            check("first", v_first, int'(e.lay == 0));
            check("lay_en", v_layen, int'(e.butt == 0));
          end
        end
        if (v_wre != 0) begin
          if (wr_q.size() == 0) check($sformatf("wr_unexpected_i%0d", i), v_wrb, -1);
          else begin
            e = wr_q.pop_front();
            check("wr_inst", 32'(i), e.inst);
            check("wr_cyc", 32'(cyc), e.cyc);
            check("wr_lay", v_wrl, e.lay);
            check("wr_butt", v_wrb, e.butt);
          end
        end
        if (v_done != 0) begin
          if (dn_q.size() == 0) check($sformatf("done_unexpected_i%0d", i), 32'(cyc), -1);
          else begin
            e = dn_q.pop_front();
            check("done_inst", 32'(i), e.inst);
            check("done_cyc", 32'(cyc), e.cyc);
            check("busy_len", 32'(busy_cnt[i]), e.busy);
          end
          busy_cnt[i] = 0;
        end else if (v_busy != 0) begin
          busy_cnt[i]++;
        end else begin
          busy_cnt[i] = 0;
        end
      end
    end
  end

  initial begin
    repeat (5000) @(posedge CLK);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    RST = 1'b0; EN = 1'b1; START = 1'b0; ABORT = 1'b0;
    START_S = 1'b0; EN_S = 1'b1; ABORT_S = 1'b0;

    // Reset state
    repeat (2) begin
      @(negedge CLK);
      check("reset_outs", 32'({rd_en, first, lay_en, wr_en, busy, done,
                               rd_butt, rd_lay, wr_butt, wr_lay}), 0);
      check("reset_outs_s", 32'({rd_en_s, first_s, lay_en_s, wr_en_s, busy_s, done_s,
                                 rd_butt_s, rd_lay_s, wr_butt_s, wr_lay_s}), 0);
    end
    @(posedge CLK);
    #1 RST = 1'b1;

    // Full default run
    start_run(0, s);
    push_run(0, s, 5, 16, 2, BIG, 0, BIG);
    wait_cyc(s + 95);

    // Minimal configuration
    start_run(1, s);
    push_run(1, s, 1, 2, 1, BIG, 0, BIG);
    wait_cyc(s + 6);

    // EN stall of 3 cycles at layer 2, butt 7
    start_run(0, s);
    push_run(0, s, 5, 16, 2, s + 43, 3, BIG);
    wait_cyc(s + 43);
    EN = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("stall_rd_en", 32'(rd_en), 0);
      check("stall_wr_en", 32'(wr_en), 0);
      check("stall_rd_butt", 32'(rd_butt), 7);
      check("stall_rd_lay", 32'(rd_lay), 2);
      @(posedge CLK);
      #1;
    end
    EN = 1'b1;
    wait_cyc(s + 98);

    // START during BUSY and during DONE is ignored
    start_run(0, s);
    push_run(0, s, 5, 16, 2, BIG, 0, BIG);
    wait_cyc(s + 20);
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    wait_cyc(s + 90);
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      check("no_restart_busy", 32'(busy), 0);
      check("no_restart_rd_en", 32'(rd_en), 0);
      @(posedge CLK);
      #1;
    end

    // Reset in the first DRAIN cycle of layer 3
    start_run(0, s);
    push_run(0, s, 5, 16, 2, BIG, 0, s + 70);
    wait_cyc(s + 70);
    RST = 1'b0;
    @(negedge CLK);
    check("midreset_outs", 32'({rd_en, first, lay_en, wr_en, busy, done,
                                rd_butt, rd_lay, wr_butt, wr_lay}), 0);
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    check("post_reset_busy", 32'(busy), 0);
    check("post_reset_wr_en", 32'(wr_en), 0);
    start_run(0, s);
    push_run(0, s, 5, 16, 2, BIG, 0, BIG);
    wait_cyc(s + 95);

    // ABORT at layer 1, butt 5
    start_run(0, s);
`ifdef CU_FFT_ABORT_EN
    push_run(0, s, 5, 16, 2, BIG, 0, s + 24);
`else
    push_run(0, s, 5, 16, 2, BIG, 0, BIG);
`endif
    wait_cyc(s + 23);
    ABORT = 1'b1;
    @(posedge CLK);
    #1 ABORT = 1'b0;
    @(negedge CLK);
`ifdef CU_FFT_ABORT_EN
    check("abort_busy", 32'(busy), 0);
    check("abort_wr_en", 32'(wr_en), 0);
`else
    check("abort_ignored_busy", 32'(busy), 1);
    check("abort_ignored_wr_en", 32'(wr_en), 1);
`endif
    wait_cyc(s + 95);

    // Everything expected must have been seen
    check("rd_queue_left", 32'(rd_q.size()), 0);
    check("wr_queue_left", 32'(wr_q.size()), 0);
    check("done_queue_left", 32'(dn_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
